oled_text_renderer: RTL

- Sequences 8x8 glyph rendering of a short text string onto the 96x64 RGB OLED panel (12 text columns x 8 text rows).
- Accepts a text request, issues a window command for the target cell span, then walks the glyph rows through the font-map ROM.
- Emits a row-major RGB565 pixel stream to the OLED pixel writer.
- Sits between the tester status logic (requester) and the OLED command/pixel interface; it is the only sequencer of the font map.

---
 rtl/oled_text_renderer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/oled_text_renderer.sv
// Renders up to MAX_CHARS 8x8 glyphs on one text row of the 96x64 OLED:
// issues a window command, then streams RGB565 pixels row-major across the span.
module oled_text_renderer #(
  parameter int MAX_CHARS = 3,
  parameter int CODE_W    = 7,
  parameter int ROM_LAT   = 1,
  parameter int COLS      = 12,
  parameter int ROWS      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_col,
  input  logic [2:0]                    req_row,
  input  logic [1:0]                    req_len,
  input  logic [MAX_CHARS*CODE_W-1:0]   req_text,
  input  logic [15:0]                   req_fg,
  input  logic [15:0]                   req_bg,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [6:0]                    win_x0,
  output logic [6:0]                    win_x1,
  output logic [5:0]                    win_y0,
  output logic [5:0]                    win_y1,
  output logic [CODE_W+2:0]             glyph_addr,
  input  logic [7:0]                    glyph_bits,
  output logic                          px_valid,
  input  logic                          px_ready,
  output logic [15:0]                   px_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // WIN   | window command offered until win_ready
  // FETCH | glyph_addr presented to the font ROM for one cycle
  // WAIT  | ROM_LAT cycles, glyph_bits loaded on the last edge
  // PIX   | 8 pixel beats of the current glyph row
  // DONE  | one-cycle done (and err on reject) pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WIN, S_FETCH, S_WAIT, S_PIX, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]                  len_q;
  logic [MAX_CHARS*CODE_W-1:0] text_q;
  logic [15:0]                 fg_q, bg_q;
  logic                        rej_q;
  logic [1:0]                  c;
  logic [2:0]                  r;
  logic [2:0]                  beat;
  logic [1:0]                  wcnt;
  logic [7:0]                  sh;
  logic [CODE_W+2:0]           ga_q;
  logic [CODE_W-1:0]           cur_code;
  logic [CODE_W+2:0]           cur_addr;
  int                          eff, avail, lim;
  logic                        px_fire, last_beat, last_col, last_row;

  always_comb begin
    avail = COLS - int'(req_col);
    lim   = (int'(req_len) > MAX_CHARS) ? MAX_CHARS : int'(req_len);
    if (int'(req_col) >= COLS) eff = 0;
    else if (lim > avail)      eff = avail;
    else                       eff = lim;
  end

  always_comb begin
    cur_code = '0;
    for (int i = 0; i < MAX_CHARS; i++)
      if (int'(c) == i) cur_code = text_q[i*CODE_W +: CODE_W];
    cur_addr = {cur_code, r};
  end

  assign px_fire   = (state == S_PIX) && px_ready;
  assign last_beat = (beat == 3'd7);
  assign last_col  = (c == len_q - 2'd1);
  assign last_row  = (r == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = (eff == 0) ? S_DONE : S_WIN;
      S_WIN:   if (win_ready) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  if (wcnt == 2'd0) state_nxt = S_PIX;
      S_PIX:   if (px_fire && last_beat)
                 state_nxt = (last_col && last_row) ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    win_valid = (state == S_WIN);
    px_valid  = (state == S_PIX);
    done      = (state == S_DONE);
    err       = (state == S_DONE) && rej_q;
  end

  // ga_q keeps the last fetched address visible while the ROM pipeline drains
  assign glyph_addr = (state == S_FETCH) ? cur_addr : ga_q;
  assign px_data    = sh[0] ? fg_q : bg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      text_q <= '0;
      fg_q   <= '0;
      bg_q   <= '0;
      rej_q  <= 1'b0;
      c      <= '0;
      r      <= '0;
      beat   <= '0;
      wcnt   <= '0;
      sh     <= '0;
      ga_q   <= '0;
      win_x0 <= '0;
      win_x1 <= '0;
      win_y0 <= '0;
      win_y1 <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          len_q  <= 2'(eff);
          text_q <= req_text;
          fg_q   <= req_fg;
          bg_q   <= req_bg;
          rej_q  <= (int'(req_col) >= COLS);
          c      <= '0;
          r      <= '0;
          win_x0 <= {req_col, 3'b000};
          win_x1 <= 7'(int'(req_col) * 8 + eff * 8 - 1);
          win_y0 <= {3'(int'(req_row) % ROWS), 3'b000};
          win_y1 <= {3'(int'(req_row) % ROWS), 3'b111};
        end
        S_FETCH: begin
          ga_q <= cur_addr;
          wcnt <= 2'(ROM_LAT - 1);
        end
        S_WAIT: begin
          if (wcnt == 2'd0) begin
            sh   <= glyph_bits;
            beat <= '0;
          end else begin
            wcnt <= wcnt - 2'd1;
          end
        end
        S_PIX: if (px_fire) begin
          sh   <= sh >> 1;
          beat <= beat + 3'd1;
          if (last_beat) begin
            if (last_col) begin
              c <= '0;
              r <= r + 3'd1;
            end else begin
              c <= c + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
